// File: rtl/rmii_tx.sv
// rmii_tx: RMII transmit framer.
// Accepts a byte stream over a valid/request handshake and serialises it as
// RMII dibits (LSB dibit first). The framer adds the preamble and SFD,
// optionally appends the Ethernet CRC-32 FCS, and enforces the inter-frame gap.
// Runs on the 100 MHz system clock. The 50 MHz RMII reference is sampled as data,
// and every transmit decision is made on its rising-edge tick.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   clk50Mgz        50 MHz RMII reference clock (sampled)
//   byteIn          next payload byte
//   dataValid       byteIn/dataLast valid; in IDLE, starts a frame
//   dataLast        byteIn is the final payload byte
//   dataReq         1-clk pulse: byteIn latched, upstream advances
//   TXD, TX_EN      RMII transmit dibit / enable (update on tick only)
//   busy            frame start through end of the inter-frame gap
//   txDone          1-clk pulse on the tick after the final dibit
//   txErr           1-clk pulse when an underrun aborts the frame
//   byteCount       payload bytes latched in the current frame
module rmii_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int APPEND_FCS     = 1,
  parameter int IFG_DIBITS     = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk50Mgz,
  input  logic [7:0]  byteIn,
  input  logic        dataValid,
  input  logic        dataLast,
  output logic        dataReq,
  output logic [1:0]  TXD,
  output logic        TX_EN,
  output logic        busy,
  output logic        txDone,
  output logic        txErr,
  output logic [15:0] byteCount
);
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [15:0] SFD_LAST = 16'(4 * PREAMBLE_BYTES + 3);
  localparam logic [15:0] IFG_LAST = 16'(IFG_DIBITS - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, IFG} state_t;
  state_t state, state_n;

  // Two synchroniser flops, plus a third stage that provides the edge-detect history.
  logic [2:0] c50_pipe;
  logic       tick;

  always_ff @(posedge clk or posedge rst)
    if (rst) c50_pipe <= '0;
    else     c50_pipe <= {c50_pipe[1:0], clk50Mgz};

  assign tick = c50_pipe[1] & ~c50_pipe[2];

  // Reflected CRC-32, advanced two bits at a time (bit 0 of the dibit goes first).
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  logic [15:0] cnt, cnt_n;       // dibit index within the current state
  logic [31:0] sr, sr_n;         // outgoing byte, or the FCS word while in FCS
  logic [31:0] crc, crc_n, crc_d;
  logic        last_q, last_n;
  logic        done_pend, done_pend_n;
  logic [1:0]  txd_n;
  logic        txen_n, busy_n, req_n, done_n, err_n, latch;
  logic [15:0] bc_n;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sr_n        = sr;
    crc_n       = crc;
    last_n      = last_q;
    done_pend_n = done_pend;
    txd_n       = TXD;
    txen_n      = TX_EN;
    busy_n      = busy;
    bc_n        = byteCount;
    req_n       = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    latch       = 1'b0;
    crc_d       = crc_dibit(crc, sr[1:0]);
    if (tick) begin
      unique case (state)
        IDLE: begin
          txd_n  = 2'b00;
          txen_n = 1'b0;
          // The tick that accepts the frame also drives its first preamble dibit.
          if (dataValid) begin
            state_n = PREAMBLE;
            busy_n  = 1'b1;
            bc_n    = '0;
            crc_n   = '1;
            txd_n   = 2'b01;
            txen_n  = 1'b1;
            cnt_n   = 16'd1;
          end
        end
        PREAMBLE: begin
          txen_n = 1'b1;
          txd_n  = (cnt == SFD_LAST) ? 2'b11 : 2'b01;
          cnt_n  = cnt + 16'd1;
          latch  = (cnt == SFD_LAST);
        end
        DATA: begin
          txen_n = 1'b1;
          txd_n  = sr[1:0];
          crc_n  = crc_d;
          sr_n   = sr >> 2;
          cnt_n  = cnt + 16'd1;
          if (cnt == 16'd3) begin
            cnt_n = '0;
            if (!last_q) begin
              latch = 1'b1;
            end else if (APPEND_FCS != 0) begin
              // crc_d already includes the dibit being sent on this tick.
              state_n = FCS;
              sr_n    = ~crc_d;
            end else begin
              state_n     = IFG;
              done_pend_n = 1'b1;
            end
          end
        end
        FCS: begin
          txen_n = 1'b1;
          txd_n  = sr[1:0];
          sr_n   = sr >> 2;
          cnt_n  = cnt + 16'd1;
          if (cnt == 16'd15) begin
            state_n     = IFG;
            cnt_n       = '0;
            done_pend_n = 1'b1;
          end
        end
        IFG: begin
          // The first gap tick is the "tick after the final dibit", so txDone fires here.
          txen_n      = 1'b0;
          txd_n       = 2'b00;
          done_n      = done_pend;
          done_pend_n = 1'b0;
          cnt_n       = cnt + 16'd1;
          if (cnt == IFG_LAST) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase

      // Byte hand-off: either take the next byte, or abort on underrun.
      if (latch) begin
        cnt_n = '0;
        if (dataValid) begin
          sr_n    = {24'h0, byteIn};
          last_n  = dataLast;
          req_n   = 1'b1;
          bc_n    = byteCount + 16'd1;
          state_n = DATA;
        end else begin
          err_n       = 1'b1;
          done_pend_n = 1'b0;
          state_n     = IFG;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      crc       <= '1;
      last_q    <= 1'b0;
      done_pend <= 1'b0;
      TXD       <= 2'b00;
      TX_EN     <= 1'b0;
      busy      <= 1'b0;
      byteCount <= '0;
      dataReq   <= 1'b0;
      txDone    <= 1'b0;
      txErr     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sr        <= sr_n;
      crc       <= crc_n;
      last_q    <= last_n;
      done_pend <= done_pend_n;
      TXD       <= txd_n;
      TX_EN     <= txen_n;
      busy      <= busy_n;
      byteCount <= bc_n;
      dataReq   <= req_n;
      txDone    <= done_n;
      txErr     <= err_n;
    end
  end
endmodule
